regfile_scoreboard: RTL and testbench

- Tracks in-flight writes to the integer (rfx) and float (rff) register files and generates the decode-stage stall on read-after-write hazards.
- Sits beside instruction decode:
  - Decode presents source/destination fields and write enables (RegWrite/RegWriteF).
  - The writeback stage reports completed writes (WE/WEF/WA).
  - The execute stage reports squashed instructions.
- Registered state is one pending-write counter per architectural register, 64 counters in total.

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_scoreboard_bank.sv | 90 +++++++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register-file write scoreboard.
package regfile_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0 = 5'd0;

    typedef enum logic {
        FILE_X = 1'b0,
        FILE_F = 1'b1
    } file_sel_e;

endpackage

// File: rtl/regfile_scoreboard_bank.sv
// Pending-write counters for one register file: hazard lookup, structural-full
// check, and counter update with underflow clamping.
module scoreboard_bank
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W              = 2,
    parameter bit BYPASS_WB          = 1'b1,
    parameter bit ZERO_REG_HARDWIRED = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_dst_we,
    input  reg_addr_t           i_dst_addr,
    input  logic                i_issue,
    input  logic                i_wb_en,
    input  reg_addr_t           i_wb_addr,
    input  logic                i_cancel_en,
    input  reg_addr_t           i_cancel_addr,
    input  logic                i_rs1_en,
    input  reg_addr_t           i_rs1_addr,
    input  logic                i_rs2_en,
    input  reg_addr_t           i_rs2_addr,
    output logic                o_rs1_hazard,
    output logic                o_rs2_hazard,
    output logic                o_dst_full,
    output logic [NUM_REGS-1:0] o_busy,
    output logic                o_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]          r_cnt     [NUM_REGS];
    logic [CNT_W-1:0]          w_cnt_nxt [NUM_REGS];
    logic signed [CNT_W+1:0]   w_net     [NUM_REGS];
    logic [NUM_REGS-1:0]       w_inc_hit;
    logic [NUM_REGS-1:0]       w_wb_hit;
    logic [NUM_REGS-1:0]       w_cn_hit;
    logic [NUM_REGS-1:0]       w_uflow;
    logic                      w_dst_req;
    logic                      w_inc;
    logic                      w_wb;
    logic                      w_cn;

    // A hardwired zero register never accumulates state, so every port ignores it.
    function automatic logic tracked(input reg_addr_t a);
        return !(ZERO_REG_HARDWIRED && (a == X0));
    endfunction

    function automatic logic src_hazard(input logic en, input reg_addr_t a,
                                        input logic [CNT_W-1:0] cnt,
                                        input logic wb, input reg_addr_t wa);
        logic bypass;
        bypass = BYPASS_WB && (cnt == CNT_W'(1)) && wb && (wa == a);
        return en && tracked(a) && (cnt != '0) && !bypass;
    endfunction

    assign w_dst_req = i_dst_we && tracked(i_dst_addr);
    assign w_inc     = i_issue && w_dst_req;
    assign w_wb      = i_wb_en && tracked(i_wb_addr);
    assign w_cn      = i_cancel_en && tracked(i_cancel_addr);

    assign o_rs1_hazard = src_hazard(i_rs1_en, i_rs1_addr, r_cnt[i_rs1_addr], w_wb, i_wb_addr);
    assign o_rs2_hazard = src_hazard(i_rs2_en, i_rs2_addr, r_cnt[i_rs2_addr], w_wb, i_wb_addr);
    assign o_dst_full   = w_dst_req && (r_cnt[i_dst_addr] == CNT_MAX);
    assign o_underflow  = |w_uflow;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc_hit[i] = w_inc && (i_dst_addr == reg_addr_t'(i));
            w_wb_hit[i]  = w_wb && (i_wb_addr == reg_addr_t'(i));
            w_cn_hit[i]  = w_cn && (i_cancel_addr == reg_addr_t'(i));
            w_net[i]     = signed'({2'b00, r_cnt[i]})
                         + signed'({{(CNT_W+1){1'b0}}, w_inc_hit[i]})
                         - signed'({{(CNT_W+1){1'b0}}, w_wb_hit[i]})
                         - signed'({{(CNT_W+1){1'b0}}, w_cn_hit[i]});
            w_uflow[i]   = w_net[i][CNT_W+1];
            w_cnt_nxt[i] = w_uflow[i] ? '0 : w_net[i][CNT_W-1:0];
            o_busy[i]    = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage RAW/structural stall generator tracking pending writes to the
// integer and float register files.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic                  id_rs1_f,
    input  logic                  id_rs2_f,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_wef,
    input  logic                  wb_we,
    input  logic                  wb_wef,
    input  logic [REG_ADDR_W-1:0] wb_wa,
    input  logic                  cancel_valid,
    input  logic [REG_ADDR_W-1:0] cancel_rd,
    input  logic                  cancel_f,
    output logic                  stall,
    output logic                  issue,
    output logic [NUM_REGS-1:0]   busy_x,
    output logic [NUM_REGS-1:0]   busy_f,
    output logic                  idle,
    output logic                  err_underflow
);

    logic w_rs1_is_f, w_rs2_is_f, w_cancel_is_f;
    logic w_x_rs1_hz, w_x_rs2_hz, w_x_full, w_x_uflow;
    logic w_f_rs1_hz, w_f_rs2_hz, w_f_full, w_f_uflow;
    logic r_err_underflow;

    assign w_rs1_is_f    = (file_sel_e'(id_rs1_f) == FILE_F);
    assign w_rs2_is_f    = (file_sel_e'(id_rs2_f) == FILE_F);
    assign w_cancel_is_f = (file_sel_e'(cancel_f) == FILE_F);

    scoreboard_bank #(
        .CNT_W              (CNT_W),
        .BYPASS_WB          (BYPASS_WB),
        .ZERO_REG_HARDWIRED (1'b1)
    ) u_bank_x (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_dst_we      (id_we),
        .i_dst_addr    (id_rd),
        .i_issue       (issue),
        .i_wb_en       (wb_we),
        .i_wb_addr     (wb_wa),
        .i_cancel_en   (cancel_valid && !w_cancel_is_f),
        .i_cancel_addr (cancel_rd),
        .i_rs1_en      (id_rs1_en && !w_rs1_is_f),
        .i_rs1_addr    (id_rs1),
        .i_rs2_en      (id_rs2_en && !w_rs2_is_f),
        .i_rs2_addr    (id_rs2),
        .o_rs1_hazard  (w_x_rs1_hz),
        .o_rs2_hazard  (w_x_rs2_hz),
        .o_dst_full    (w_x_full),
        .o_busy        (busy_x),
        .o_underflow   (w_x_uflow)
    );

    scoreboard_bank #(
        .CNT_W              (CNT_W),
        .BYPASS_WB          (BYPASS_WB),
        .ZERO_REG_HARDWIRED (1'b0)
    ) u_bank_f (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_dst_we      (id_wef),
        .i_dst_addr    (id_rd),
        .i_issue       (issue),
        .i_wb_en       (wb_wef),
        .i_wb_addr     (wb_wa),
        .i_cancel_en   (cancel_valid && w_cancel_is_f),
        .i_cancel_addr (cancel_rd),
        .i_rs1_en      (id_rs1_en && w_rs1_is_f),
        .i_rs1_addr    (id_rs1),
        .i_rs2_en      (id_rs2_en && w_rs2_is_f),
        .i_rs2_addr    (id_rs2),
        .o_rs1_hazard  (w_f_rs1_hz),
        .o_rs2_hazard  (w_f_rs2_hz),
        .o_dst_full    (w_f_full),
        .o_busy        (busy_f),
        .o_underflow   (w_f_uflow)
    );

    // Full checks depend only on registered counts, so issue feeding the banks forms no loop.
    assign stall = id_valid && (w_x_rs1_hz || w_x_rs2_hz || w_f_rs1_hz || w_f_rs2_hz ||
                                w_x_full || w_f_full);
    assign issue = id_valid && !stall;
    assign idle  = !(|busy_x) && !(|busy_f);
    assign err_underflow = r_err_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_underflow <= 1'b0;
        end else if (w_x_uflow || w_f_uflow) begin
            r_err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with an expectation queue; a second
// instance without writeback bypass runs on the same stimulus.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs1_en, id_rs2_en, id_rs1_f, id_rs2_f, id_we, id_wef;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_wa, cancel_rd;
    logic        wb_we, wb_wef, cancel_valid, cancel_f;
    logic        stall, issue, idle, err_underflow;
    logic [31:0] busy_x, busy_f;
    logic        nb_stall, nb_issue, nb_idle, nb_err;
    logic [31:0] nb_busy_x, nb_busy_f;

    always #5 clk = ~clk;

    regfile_scoreboard #(.CNT_W(2), .BYPASS_WB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rs1_f(id_rs1_f), .id_rs2_f(id_rs2_f),
        .id_rd(id_rd), .id_we(id_we), .id_wef(id_wef), .wb_we(wb_we), .wb_wef(wb_wef),
        .wb_wa(wb_wa), .cancel_valid(cancel_valid), .cancel_rd(cancel_rd), .cancel_f(cancel_f),
        .stall(stall), .issue(issue), .busy_x(busy_x), .busy_f(busy_f), .idle(idle),
        .err_underflow(err_underflow)
    );

    regfile_scoreboard #(.CNT_W(2), .BYPASS_WB(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rs1_f(id_rs1_f), .id_rs2_f(id_rs2_f),
        .id_rd(id_rd), .id_we(id_we), .id_wef(id_wef), .wb_we(wb_we), .wb_wef(wb_wef),
        .wb_wa(wb_wa), .cancel_valid(cancel_valid), .cancel_rd(cancel_rd), .cancel_f(cancel_f),
        .stall(nb_stall), .issue(nb_issue), .busy_x(nb_busy_x), .busy_f(nb_busy_f), .idle(nb_idle),
        .err_underflow(nb_err)
    );

    localparam int S_STALL = 0, S_ISSUE = 1, S_BX = 2, S_BF = 3, S_IDLE = 4, S_ERR = 5;
    localparam int S_NB_STALL = 6, S_NB_BX = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_STALL:    return {31'd0, stall};
            S_ISSUE:    return {31'd0, issue};
            S_BX:       return busy_x;
            S_BF:       return busy_f;
            S_IDLE:     return {31'd0, idle};
            S_ERR:      return {31'd0, err_underflow};
            S_NB_STALL: return {31'd0, nb_stall};
            S_NB_BX:    return nb_busy_x;
            default:    return 32'hdead_beef;
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sel);
            total++;
            assert (o === e.exp) else begin
                bad++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic clr();
        id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_rs1_f = 0; id_rs2_f = 0;
        id_we = 0; id_wef = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        wb_we = 0; wb_wef = 0; wb_wa = 0;
        cancel_valid = 0; cancel_rd = 0; cancel_f = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        want("rst_busy_x", S_BX, 32'h0);
        want("rst_busy_f", S_BF, 32'h0);
        want("rst_idle", S_IDLE, 32'h1);
        want("rst_err", S_ERR, 32'h0);
        want("rst_stall", S_STALL, 32'h0);
        want("rst_issue_novalid", S_ISSUE, 32'h0);
        check_all();
        id_valid = 1; id_rs1 = 5; id_rs1_en = 1;
        settle();
        want("rst_issue_valid", S_ISSUE, 32'h1);
        check_all();

        // RAW on x5
        clr(); id_valid = 1; id_rd = 5; id_we = 1;
        settle();
        want("raw_wr_issue", S_ISSUE, 32'h1);
        check_all();
        tick();
        want("raw_busy_x5", S_BX, 32'h20);
        check_all();
        clr(); id_valid = 1; id_rs1 = 5; id_rs1_en = 1;
        settle();
        want("raw_stall", S_STALL, 32'h1);
        want("raw_no_issue", S_ISSUE, 32'h0);
        want("raw_nb_stall", S_NB_STALL, 32'h1);
        check_all();
        tick();
        want("raw_stall_hold", S_STALL, 32'h1);
        check_all();
        wb_we = 1; wb_wa = 5;
        settle();
        want("raw_bypass_stall", S_STALL, 32'h0);
        want("raw_bypass_issue", S_ISSUE, 32'h1);
        want("raw_nobypass_stall", S_NB_STALL, 32'h1);
        check_all();
        tick();
        wb_we = 0;
        settle();
        want("raw_busy_clear", S_BX, 32'h0);
        want("raw_nb_busy_clear", S_NB_BX, 32'h0);
        want("raw_nb_stall_drop", S_NB_STALL, 32'h0);
        check_all();

        // x0 never tracked, f0 is
        clr(); id_valid = 1; id_rd = 0; id_we = 1;
        settle();
        want("x0_issue", S_ISSUE, 32'h1);
        check_all();
        tick();
        want("x0_busy_x", S_BX, 32'h0);
        want("x0_idle", S_IDLE, 32'h1);
        check_all();
        clr(); id_valid = 1; id_rd = 0; id_wef = 1;
        settle();
        tick();
        want("f0_busy_f", S_BF, 32'h1);
        check_all();
        clr(); id_valid = 1; id_rs1 = 0; id_rs1_en = 1;
        settle();
        want("x0_read_nostall", S_STALL, 32'h0);
        check_all();
        id_rs1_f = 1;
        settle();
        want("f0_read_stall", S_STALL, 32'h1);
        want("f0_not_idle", S_IDLE, 32'h0);
        check_all();
        clr(); wb_wef = 1; wb_wa = 0;
        settle();
        tick();
        clr();
        settle();
        want("f0_freed", S_BF, 32'h0);
        want("f0_idle", S_IDLE, 32'h1);
        check_all();

        // Saturation on f3
        clr(); id_valid = 1; id_rd = 3; id_wef = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            want("sat_issue", S_ISSUE, 32'h1);
            check_all();
            tick();
        end
        want("sat_busy_f3", S_BF, 32'h8);
        want("sat_full_stall", S_STALL, 32'h1);
        want("sat_full_noissue", S_ISSUE, 32'h0);
        check_all();
        tick();
        want("sat_still_f3", S_BF, 32'h8);
        check_all();
        wb_wef = 1; wb_wa = 3;
        settle();
        want("sat_stall_during_wb", S_STALL, 32'h1);
        check_all();
        tick();
        wb_wef = 0;
        settle();
        want("sat_fourth_nostall", S_STALL, 32'h0);
        want("sat_fourth_issue", S_ISSUE, 32'h1);
        check_all();
        tick();
        clr(); wb_wef = 1; wb_wa = 3;
        settle();
        want("sat_refilled", S_BF, 32'h8);
        check_all();
        tick(); tick(); tick();
        clr();
        settle();
        want("sat_drained", S_BF, 32'h0);
        want("sat_no_err", S_ERR, 32'h0);
        check_all();

        // Simultaneous issue and writeback on x7
        clr(); id_valid = 1; id_rd = 7; id_we = 1;
        settle();
        tick();
        want("sim_busy_x7", S_BX, 32'h80);
        check_all();
        wb_we = 1; wb_wa = 7;
        settle();
        want("sim_issue", S_ISSUE, 32'h1);
        check_all();
        tick();
        want("sim_unchanged", S_BX, 32'h80);
        check_all();
        clr(); wb_we = 1; wb_wa = 7;
        settle();
        tick();
        clr();
        settle();
        want("sim_freed", S_BX, 32'h0);
        check_all();

        // Writeback and cancel together on x9, then underflow
        clr(); id_valid = 1; id_rd = 9; id_we = 1;
        settle();
        tick();
        tick();
        clr();
        settle();
        want("cn_busy_x9", S_BX, 32'h200);
        check_all();
        wb_we = 1; wb_wa = 9; cancel_valid = 1; cancel_rd = 9; cancel_f = 0;
        settle();
        tick();
        clr();
        settle();
        want("cn_double_dec", S_BX, 32'h0);
        want("cn_idle", S_IDLE, 32'h1);
        want("cn_no_err", S_ERR, 32'h0);
        check_all();
        cancel_valid = 1; cancel_rd = 9;
        settle();
        tick();
        clr();
        settle();
        want("uf_err_set", S_ERR, 32'h1);
        want("uf_clamped", S_BX, 32'h0);
        check_all();
        tick();
        want("uf_err_sticky", S_ERR, 32'h1);
        check_all();

        // Reset while counters are nonzero
        clr(); id_valid = 1; id_rd = 12; id_we = 1;
        settle();
        tick();
        clr(); id_valid = 1; id_rd = 4; id_wef = 1;
        settle();
        tick();
        clr();
        settle();
        want("mid_busy_x", S_BX, 32'h1000);
        want("mid_busy_f", S_BF, 32'h10);
        check_all();
        rst_n = 1'b0;
        settle();
        tick();
        rst_n = 1'b1;
        settle();
        want("mid_rst_busy_x", S_BX, 32'h0);
        want("mid_rst_busy_f", S_BF, 32'h0);
        want("mid_rst_idle", S_IDLE, 32'h1);
        want("mid_rst_err", S_ERR, 32'h0);
        check_all();
        id_valid = 1; id_rs1 = 12; id_rs1_en = 1; id_rs2 = 4; id_rs2_en = 1; id_rs2_f = 1;
        settle();
        want("mid_rst_stall", S_STALL, 32'h0);
        want("mid_rst_issue", S_ISSUE, 32'h1);
        want("mid_rst_nb_stall", S_NB_STALL, 32'h0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
